// File: rtl/ram_dp_clr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ram_dp_clr
// Purpose : Parametrised dual-port data RAM.
//           - Port A reads and writes.
//           - Port B is read-only.
//           - Both ports have registered 1-cycle reads and valid strobes.
//           - A built-in clear engine zeroes the whole array after reset
//             (optional) or when the clear input is pulsed.
// Ports   : clk, rst_n (sync, active-low)
//           address_a, in_a, load_a, rd_a -> out_a, valid_a   (port A)
//           address_b, rd_b               -> out_b, valid_b   (port B)
//           clear -> busy                                    (clear engine)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module ram_dp_clr #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic                  load_a,
    input  logic                  rd_a,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic                  valid_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  rd_b,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  valid_b,
    input  logic                  clear,
    output logic                  busy
);

    localparam int                    c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = '1;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    logic                  w_run;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_din;

    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;
    logic                  r_valid_a;
    logic                  r_valid_b;

    //--------------------------------------------------------------------------
    // State register (also holds the clear counter)
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                // The counter wraps to 0 naturally after the last word.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                if (clear) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output / control decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_run      = (r_state == S_RUN);
        busy       = !w_run;
        // Writes are suppressed on reset edges so that rst_n never alters
        // memory contents on its own.
        w_mem_we   = rst_n && (w_run ? load_a : 1'b1);
        w_mem_addr = w_run ? address_a : r_cnt;
        w_mem_din  = w_run ? in_a : '0;
    end

    //--------------------------------------------------------------------------
    // Memory array (no reset, single write port)
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    //--------------------------------------------------------------------------
    // Registered read ports
    //--------------------------------------------------------------------------
    // Port A is write-first. Port B bypasses a concurrent port-A write to
    // the same address, so both ports see the new word on a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_a   <= '0;
            r_out_b   <= '0;
            r_valid_a <= 1'b0;
            r_valid_b <= 1'b0;
        end else begin
            r_valid_a <= w_run && rd_a;
            r_valid_b <= w_run && rd_b;
            if (w_run && rd_a) begin
                r_out_a <= load_a ? in_a : r_mem[address_a];
            end
            if (w_run && rd_b) begin
                r_out_b <= (load_a && (address_b == address_a)) ? in_a
                                                                 : r_mem[address_b];
            end
        end
    end

    assign out_a   = r_out_a;
    assign out_b   = r_out_b;
    assign valid_a = r_valid_a;
    assign valid_b = r_valid_b;

endmodule
`default_nettype wire
